// File: rtl/topolar_pipe_if.sv
// Sample/result bundle for the rectangular-to-polar CORDIC pipe.
// The source side drives ce/valid/xval/yval/tag; the pipe drives the res_* results.
interface topolar_pipe_if #(
  parameter int IW = 12,
  parameter int OW = 12,
  parameter int TW = 1
);
  logic          ce;
  logic          valid;
  logic [IW-1:0] xval;
  logic [IW-1:0] yval;
  logic [TW-1:0] tag;
  logic          res_valid;
  logic [OW-1:0] phase;
  logic [IW:0]   mag;
  logic [TW-1:0] res_tag;

  modport master (
    output ce, valid, xval, yval, tag,
    input  res_valid, phase, mag, res_tag
  );

  modport slave (
    input  ce, valid, xval, yval, tag,
    output res_valid, phase, mag, res_tag
  );
endinterface

// File: rtl/topolar_pipe.sv
// Fully pipelined rectangular-to-polar CORDIC: pre-rotation, NSTAGES micro-rotations
// and an output register; valid and tag ride along with the data.
module topolar_pipe #(
  parameter int IW      = 12,
  parameter int OW      = 12,
  parameter int NSTAGES = 10,
  parameter int XTRA    = 2,
  parameter int TW      = 1
) (
  input  logic            clk,
  input  logic            rst,
  topolar_pipe_if.slave   bus
);
  localparam int WW = IW + XTRA + 2;
  localparam int PW = OW + 4;
  localparam int MW = IW + 1;

  localparam logic [PW-1:0] PH_1_8 = {3'b001, {(PW-3){1'b0}}};
  localparam logic [PW-1:0] PH_3_8 = {3'b011, {(PW-3){1'b0}}};
  localparam logic [PW-1:0] PH_5_8 = {3'b101, {(PW-3){1'b0}}};
  localparam logic [PW-1:0] PH_7_8 = {3'b111, {(PW-3){1'b0}}};
  localparam logic [PW-1:0] PH_HALF_LSB = {{OW{1'b0}}, 1'b1, {(PW-OW-1){1'b0}}};
  localparam logic signed [WW-1:0] MAG_MAX = {{(WW-MW){1'b0}}, {MW{1'b1}}};

  // atan(2^-(k+1)) as a fraction of a full turn, scaled by 2^32
  function automatic logic [31:0] atan_turns32(input int k);
    case (k)
      0:       return 32'h12e4051d;
      1:       return 32'h09fb385b;
      2:       return 32'h051111d4;
      3:       return 32'h028b0d43;
      4:       return 32'h0145d7e1;
      5:       return 32'h00a2f61e;
      6:       return 32'h00517c55;
      7:       return 32'h0028be53;
      8:       return 32'h00145f2e;
      9:       return 32'h000a2f98;
      10:      return 32'h000517cc;
      11:      return 32'h00028be6;
      12:      return 32'h000145f3;
      13:      return 32'h0000a2f9;
      14:      return 32'h0000517c;
      15:      return 32'h000028be;
      default: return 32'h0;
    endcase
  endfunction

  // Round the 32-bit turn fraction to the internal phase width
  function automatic logic [PW-1:0] atan_entry(input int k);
    logic [63:0] scaled;
    scaled = ({32'd0, atan_turns32(k)} + (64'd1 << (31 - PW))) >> (32 - PW);
    return scaled[PW-1:0];
  endfunction

  logic signed [WW-1:0] xv_reg  [0:NSTAGES];
  logic signed [WW-1:0] yv_reg  [0:NSTAGES];
  logic        [PW-1:0] ph_reg  [0:NSTAGES];
  logic                 vld_reg [0:NSTAGES];
  logic        [TW-1:0] tag_reg [0:NSTAGES];

  logic signed [WW-1:0] xv_next  [0:NSTAGES];
  logic signed [WW-1:0] yv_next  [0:NSTAGES];
  logic        [PW-1:0] ph_next  [0:NSTAGES];
  logic                 vld_next [0:NSTAGES];
  logic        [TW-1:0] tag_next [0:NSTAGES];

  logic signed [WW-1:0] x_ext;
  logic signed [WW-1:0] y_ext;
  logic signed [WW-1:0] pre_x;
  logic signed [WW-1:0] pre_y;
  logic        [PW-1:0] pre_ph;

  assign x_ext = {{(WW-IW){bus.xval[IW-1]}}, bus.xval} << XTRA;
  assign y_ext = {{(WW-IW){bus.yval[IW-1]}}, bus.yval} << XTRA;

  // Pre-rotation by +/-45 or +/-135 degrees lands the vector in the right half-plane
  always_comb begin
    pre_x  = x_ext + y_ext;
    pre_y  = y_ext - x_ext;
    pre_ph = PH_1_8;
    case ({bus.xval[IW-1], bus.yval[IW-1]})
      2'b01: begin
        pre_x  = x_ext - y_ext;
        pre_y  = x_ext + y_ext;
        pre_ph = PH_7_8;
      end
      2'b10: begin
        pre_x  = y_ext - x_ext;
        pre_y  = -x_ext - y_ext;
        pre_ph = PH_3_8;
      end
      2'b11: begin
        pre_x  = -x_ext - y_ext;
        pre_y  = x_ext - y_ext;
        pre_ph = PH_5_8;
      end
      default: ;
    endcase
  end

  assign xv_next[0]  = pre_x;
  assign yv_next[0]  = pre_y;
  assign ph_next[0]  = pre_ph;
  assign vld_next[0] = bus.valid;
  assign tag_next[0] = bus.tag;

  generate
    for (genvar gi = 0; gi < NSTAGES; gi++) begin : g_stage
      localparam logic [PW-1:0] ANGLE = atan_entry(gi);

      assign vld_next[gi+1] = vld_reg[gi];
      assign tag_next[gi+1] = tag_reg[gi];

      if (ANGLE == '0) begin : g_pass
        // Angle too small to register at this phase width: stage is a plain delay
        assign xv_next[gi+1] = xv_reg[gi];
        assign yv_next[gi+1] = yv_reg[gi];
        assign ph_next[gi+1] = ph_reg[gi];
      end else begin : g_rot
        logic signed [WW-1:0] x_sh;
        logic signed [WW-1:0] y_sh;
        logic                 y_neg;

        assign x_sh  = xv_reg[gi] >>> (gi + 1);
        assign y_sh  = yv_reg[gi] >>> (gi + 1);
        assign y_neg = yv_reg[gi][WW-1];

        assign xv_next[gi+1] = y_neg ? (xv_reg[gi] - y_sh) : (xv_reg[gi] + y_sh);
        assign yv_next[gi+1] = y_neg ? (yv_reg[gi] + x_sh) : (yv_reg[gi] - x_sh);
        assign ph_next[gi+1] = y_neg ? (ph_reg[gi] - ANGLE) : (ph_reg[gi] + ANGLE);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= NSTAGES; i++) begin
        xv_reg[i]  <= '0;
        yv_reg[i]  <= '0;
        ph_reg[i]  <= '0;
        vld_reg[i] <= 1'b0;
        tag_reg[i] <= '0;
      end
    end else if (bus.ce) begin
      for (int i = 0; i <= NSTAGES; i++) begin
        xv_reg[i]  <= xv_next[i];
        yv_reg[i]  <= yv_next[i];
        ph_reg[i]  <= ph_next[i];
        vld_reg[i] <= vld_next[i];
        tag_reg[i] <= tag_next[i];
      end
    end
  end

  logic signed [WW-1:0] mag_full;
  logic        [MW-1:0] mag_sat;
  logic        [PW-1:0] ph_rounded;
  logic                 unused_bits;

  assign mag_full   = xv_reg[NSTAGES] >>> XTRA;
  // Adding half an output LSB before truncation rounds half-up and wraps max+0.5 to 0
  assign ph_rounded = ph_reg[NSTAGES] + PH_HALF_LSB;
  assign unused_bits = ^{ph_rounded[PW-OW-1:0], yv_reg[NSTAGES]};

  always_comb begin
    mag_sat = mag_full[MW-1:0];
    if (mag_full[WW-1]) begin
      mag_sat = '0;
    end else if (mag_full > MAG_MAX) begin
      mag_sat = '1;
    end
  end

  logic          valid_out_reg;
  logic [OW-1:0] phase_reg;
  logic [MW-1:0] mag_reg;
  logic [TW-1:0] tag_out_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out_reg <= 1'b0;
      phase_reg     <= '0;
      mag_reg       <= '0;
      tag_out_reg   <= '0;
    end else if (bus.ce) begin
      valid_out_reg <= vld_reg[NSTAGES];
      phase_reg     <= ph_rounded[PW-1:PW-OW];
      mag_reg       <= mag_sat;
      tag_out_reg   <= tag_reg[NSTAGES];
    end
  end

  assign bus.res_valid = valid_out_reg;
  assign bus.phase     = phase_reg;
  assign bus.mag       = mag_reg;
  assign bus.res_tag   = tag_out_reg;
endmodule

// File: tb/tb_topolar_pipe.sv
// Scoreboard bench for topolar_pipe: accepted samples are queued with their enable index,
// a monitor pops and checks each result against an atan2/hypot reference.
`timescale 1ns/1ps
module tb_topolar_pipe;
  localparam int IW = 12, OW = 12, NSTAGES = 10, XTRA = 2, TW = 1;
  localparam int MW = IW + 1;
  localparam int LAT = NSTAGES + 2;
  localparam int NRAND = 200;
  localparam real PI = 3.14159265358979323846;
  localparam real GAIN = 1.6467602;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  topolar_pipe_if #(.IW(IW), .OW(OW), .TW(TW)) bus ();

  topolar_pipe #(.IW(IW), .OW(OW), .NSTAGES(NSTAGES), .XTRA(XTRA), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int idx;
    int x;
    int y;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  bit   vhist[int];
  int   ce_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  int   mode = 0;      // 0 plain, 1 record results, 2 compare with recorded results
  int   cmp_ptr = 0;
  int   rec_phase[$];
  int   rec_mag[$];
  int   rec_tag[$];
  int   px[NRAND];
  int   py[NRAND];
  bit   ce_s, rst_s;
  int   prev_valid, prev_phase, prev_mag, prev_tag;

  task automatic report(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Input side: every enabled edge is logged, accepted samples enter the scoreboard
  always @(posedge clk) begin
    if (!rst && bus.ce) begin
      ce_cnt++;
      vhist[ce_cnt] = bus.valid;
      if (bus.valid)
        exp_q.push_back('{ce_cnt, int'($signed(bus.xval)), int'($signed(bus.yval)), int'(bus.tag)});
    end
  end

  task automatic check_result();
    exp_t e;
    real  refp, refm, d, tol;
    int   ph, mg, m;
    m  = ce_cnt;
    ph = int'(bus.phase);
    mg = int'(bus.mag);
    if (exp_q.size() == 0) begin
      report("unexpected_output", 1'b0, $sformatf("got valid output at enable %0d, required none", m));
      return;
    end
    e = exp_q.pop_front();
    $display("out idx=%0d x=%0d y=%0d tag=%0d phase=%0d mag=%0d", e.idx, e.x, e.y, int'(bus.res_tag), ph, mg);
    report("latency", (m - e.idx + 1) == LAT,
           $sformatf("got %0d cycles, required %0d", m - e.idx + 1, LAT));
    report("tag", int'(bus.res_tag) == e.tag,
           $sformatf("got %0d, required %0d", int'(bus.res_tag), e.tag));
    refm = GAIN * $sqrt(real'(e.x * e.x + e.y * e.y));
    if (refm > real'((1 << MW) - 1)) refm = real'((1 << MW) - 1);
    tol = 2.0 + refm / 1200.0;
    d = real'(mg) - refm;
    report("magnitude", (d <= tol) && (d >= -tol),
           $sformatf("(%0d,%0d) got %0d, required %0.1f +/- %0.1f", e.x, e.y, mg, refm, tol));
    if (e.x != 0 || e.y != 0) begin
      refp = $atan2(real'(e.y), real'(e.x)) / (2.0 * PI) * real'(1 << OW);
      if (refp < 0.0) refp = refp + real'(1 << OW);
      d = real'(ph) - refp;
      while (d > real'(1 << (OW - 1))) d = d - real'(1 << OW);
      while (d < -real'(1 << (OW - 1))) d = d + real'(1 << OW);
      report("phase", (d <= 2.0) && (d >= -2.0),
             $sformatf("(%0d,%0d) got %0d, required %0.1f +/- 2", e.x, e.y, ph, refp));
    end
    if (mode == 1) begin
      rec_phase.push_back(ph);
      rec_mag.push_back(mg);
      rec_tag.push_back(int'(bus.res_tag));
    end else if (mode == 2) begin
      if (cmp_ptr < rec_phase.size())
        report("gated_rerun", ph == rec_phase[cmp_ptr] && mg == rec_mag[cmp_ptr] &&
               int'(bus.res_tag) == rec_tag[cmp_ptr],
               $sformatf("item %0d got %0d/%0d/%0d, required %0d/%0d/%0d", cmp_ptr, ph, mg,
                         int'(bus.res_tag), rec_phase[cmp_ptr], rec_mag[cmp_ptr], rec_tag[cmp_ptr]));
      else
        report("gated_rerun", 1'b0, $sformatf("extra item %0d, required at most %0d", cmp_ptr, rec_phase.size()));
      cmp_ptr++;
    end
  endtask

  // Output side: sampled 1ns after each edge
  always @(posedge clk) begin
    ce_s  = bus.ce;
    rst_s = rst;
    #1;
    if (!rst_s && !rst) begin
      if (ce_s) begin
        int exp_v;
        exp_v = 0;
        if (ce_cnt > NSTAGES + 1 && vhist.exists(ce_cnt - NSTAGES - 1))
          exp_v = int'(vhist[ce_cnt - NSTAGES - 1]);
        report("valid_pattern", int'(bus.res_valid) == exp_v,
               $sformatf("enable %0d got %0d, required %0d", ce_cnt, bus.res_valid, exp_v));
        if (bus.res_valid) check_result();
      end else begin
        report("hold", int'(bus.res_valid) == prev_valid && int'(bus.phase) == prev_phase &&
               int'(bus.mag) == prev_mag && int'(bus.res_tag) == prev_tag,
               $sformatf("got %0d/%0d/%0d/%0d, required %0d/%0d/%0d/%0d", bus.res_valid, bus.phase,
                         bus.mag, bus.res_tag, prev_valid, prev_phase, prev_mag, prev_tag));
      end
    end
    prev_valid = int'(bus.res_valid);
    prev_phase = int'(bus.phase);
    prev_mag   = int'(bus.mag);
    prev_tag   = int'(bus.res_tag);
  end

  task automatic drive(input bit ce, input bit v, input int x, input int y, input int t);
    @(negedge clk);
    bus.ce    = ce;
    bus.valid = v;
    bus.xval  = x[IW-1:0];
    bus.yval  = y[IW-1:0];
    bus.tag   = t[TW-1:0];
  endtask

  task automatic rand_point(output int x, output int y);
    x = 1500;
    y = 0;
    for (int n = 0; n < 100; n++) begin
      int rx, ry;
      rx = int'($urandom_range(0, 4095)) - 2048;
      ry = int'($urandom_range(0, 4095)) - 2048;
      if (rx * rx + ry * ry >= 1024 * 1024) begin
        x = rx;
        y = ry;
        break;
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    report({name, "_valid"}, bus.res_valid == 1'b0, $sformatf("got %0d, required 0", bus.res_valid));
    report({name, "_phase"}, bus.phase == '0, $sformatf("got %0d, required 0", bus.phase));
    report({name, "_mag"}, bus.mag == '0, $sformatf("got %0d, required 0", bus.mag));
    report({name, "_tag"}, bus.res_tag == '0, $sformatf("got %0d, required 0", bus.res_tag));
  endtask

  task automatic drain();
    repeat (LAT + 3) drive(1'b1, 1'b0, 0, 0, 0);
  endtask

  int dir_x[8] = '{1000, 0, -1000, 0, 707, -2048, 0, 2047};
  int dir_y[8] = '{0, 1000, 0, -1000, 707, -2048, 0, -2048};

  initial begin
    int x, y;
    bus.ce = 1'b0; bus.valid = 1'b0; bus.xval = '0; bus.yval = '0; bus.tag = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst = 1'b0;

    // Axes, diagonal, extremes and the origin
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, dir_x[i], dir_y[i], i);
    drain();

    // Back-to-back random points, results recorded for the gated rerun
    for (int i = 0; i < NRAND; i++) rand_point(px[i], py[i]);
    mode = 1;
    for (int i = 0; i < NRAND; i++) drive(1'b1, 1'b1, px[i], py[i], i);
    drain();

    // Same points with random clock-enable gaps carrying junk inputs
    mode = 2;
    cmp_ptr = 0;
    for (int i = 0; i < NRAND; i++) begin
      while ($urandom_range(0, 2) == 0) begin
        rand_point(x, y);
        drive(1'b0, 1'($urandom_range(0, 1)), x, y, int'($urandom_range(0, 1)));
      end
      drive(1'b1, 1'b1, px[i], py[i], i);
    end
    drain();
    report("gated_rerun_count", cmp_ptr == NRAND, $sformatf("got %0d, required %0d", cmp_ptr, NRAND));
    mode = 0;

    // Bubbles every third cycle, interrupted by an asynchronous reset
    for (int c = 0; c < 40; c++) begin
      rand_point(x, y);
      drive(1'b1, (c % 3) != 2, x, y, c);
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    vhist.delete();
    ce_cnt = 0;
    #1;
    check_zero_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) begin
      rand_point(x, y);
      drive(1'b1, (c % 3) != 2, x, y, c);
    end
    drain();

    for (int n = 0; n < 50 && exp_q.size() > 0; n++) drive(1'b1, 1'b0, 0, 0, 0);
    report("drained", exp_q.size() == 0, $sformatf("got %0d pending, required 0", exp_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
